// File: rtl/sync_fifo.sv
// First-word-fall-through single-clock FIFO, any DEPTH >= 2; sticky error flags exist only when FIFO_ERR_EN is defined.
// Latency: an accepted push is visible on dout right after that edge. Status outputs decode the registered count.
// Backpressure: a push while full is dropped unless a pop is accepted on the same edge. A pop while empty is ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign dout         = empty ? '0 : mem[rd_ptr];

  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  // Storage is deliberately left out of reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) begin
        if (wr_ptr == PW'(DEPTH - 1)) wr_ptr <= '0;
        else                          wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        if (rd_ptr == PW'(DEPTH - 1)) rd_ptr <= '0;
        else                          rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  // Set terms are applied after the clear so a coincident event still latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (push & full & ~pop) overflow  <= 1'b1;
      if (pop & empty)        underflow <= 1'b1;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=5, AF=4, AE=1) with a queue scoreboard.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 5;
  localparam int AFL = 4;
  localparam int AEL = 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] din = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk(clk), .reset(reset), .din(din), .push(push), .pop(pop), .clr_err(clr_err),
    .dout(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [DW-1:0] head;
    n = sb.size();
    head = (n != 0) ? sb[0] : '0;
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AEL));
    check({tag, ".afull"}, 32'(almost_full), 32'(n >= AFL));
    check({tag, ".dout"}, 32'(dout), 32'(head));
    check({tag, ".ovf"}, 32'(overflow), 32'(ERR_EN & m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(ERR_EN & m_unf));
  endtask

  // One clock of stimulus; the scoreboard is updated from the pre-edge model state.
  task automatic step(input string tag, input bit p, input logic [DW-1:0] d, input bit r, input bit c);
    bit pa, wa;
    @(negedge clk);
    push = p; din = d; pop = r; clr_err = c;
    pa = r && (sb.size() != 0);
    wa = p && ((sb.size() != DEPTH) || pa);
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (p && sb.size() == DEPTH && !r) m_ovf = 1'b1;
    if (r && sb.size() == 0) m_unf = 1'b1;
    @(posedge clk);
    if (pa) void'(sb.pop_front());
    if (wa) sb.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    step("idle", 0, 8'h00, 0, 0);

    step("push11", 1, 8'h11, 0, 0);
    step("push22", 1, 8'h22, 0, 0);
    step("push33", 1, 8'h33, 0, 0);
    step("push44", 1, 8'h44, 0, 0);
    step("push55", 1, 8'h55, 0, 0);
    step("ovf66", 1, 8'h66, 0, 0);
    step("fullpp", 1, 8'h66, 1, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, 8'h00, 1, 0);

    step("popempty", 0, 8'h00, 1, 0);
    step("clr", 0, 8'h00, 0, 1);
    step("clrpop", 0, 8'h00, 1, 1);
    step("clr2", 0, 8'h00, 0, 1);
    step("emptypp", 1, 8'h77, 1, 0);
    step("drain77", 0, 8'h00, 1, 1);
    for (int i = 0; i < 7; i++) step("wrap", 1, 8'(8'hA0 + i), (i % 2) == 1, 0);

    step("clr3", 0, 8'h00, 0, 1);
    step("pushAA", 1, 8'hAA, 0, 0);
    step("pushBB", 1, 8'hBB, 0, 0);
    @(negedge clk);
    push = 1'b0;
    #2;
    reset = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    check_all("midreset");
    @(negedge clk);
    reset = 1'b1;
    step("pushCC", 1, 8'hCC, 0, 0);
    step("pushDD", 1, 8'hDD, 0, 0);
    step("popCC", 0, 8'h00, 1, 0);

    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
